// File: rtl/alu_writeback_stage.sv
// ALU result buffer: FIFO of {Y, tag} entries that drains into register-file writes.
// Optional operand forwarding out of the buffer is enabled by defining ALU_WB_FWD_EN.
module alu_writeback_stage #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_y,
   input  logic [4:0]                 in_op,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       wb_valid,
   input  logic                       wb_ready,
   output logic [31:0]                wb_data,
   output logic [TAG_W-1:0]           wb_tag,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [15:0]                commit_cnt,
   input  logic [TAG_W-1:0]           fwd_tag,
   output logic                       fwd_hit,
   output logic [31:0]                fwd_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);
   localparam logic [4:0] OP_NOP = 5'b11111;

   logic [31:0]      data_q [DEPTH];
   logic [TAG_W-1:0] tag_q  [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   occ_q;
   logic [15:0]      cnt_q;
   logic             push;
   logic             commit;

   // Full blocks acceptance even if a commit happens in the same cycle.
   assign in_ready = (occ_q < DEPTH_V);
   assign push     = in_valid && in_ready && (in_op != OP_NOP);
   assign commit   = (occ_q != '0) && wb_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            data_q[tail_q] <= in_y;
            tag_q[tail_q]  <= in_tag;
            tail_q         <= tail_q + 1'b1;
         end
         if (commit) begin
            head_q <= head_q + 1'b1;
            cnt_q  <= cnt_q + 16'd1;
         end
         if (push && !commit) begin
            occ_q <= occ_q + 1'b1;
         end else if (!push && commit) begin
            occ_q <= occ_q - 1'b1;
         end
      end
   end

   assign wb_valid   = (occ_q != '0);
   assign wb_data    = data_q[head_q];
   assign wb_tag     = tag_q[head_q];
   assign occupancy  = occ_q;
   assign commit_cnt = cnt_q;

`ifdef ALU_WB_FWD_EN
   logic [PTR_W-1:0] fwd_idx;

   // Walk oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < occ_q) && (tag_q[fwd_idx] == fwd_tag)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end
`else
   logic fwd_unused;
   assign fwd_unused = ^fwd_tag;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_alu_writeback_stage;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_y;
   logic [4:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             wb_valid;
   logic             wb_ready;
   logic [31:0]      wb_data;
   logic [TAG_W-1:0] wb_tag;
   logic [2:0]       occupancy;
   logic [15:0]      commit_cnt;
   logic [TAG_W-1:0] fwd_tag;
   logic             fwd_hit;
   logic [31:0]      fwd_data;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   logic [TAG_W+31:0] q[$];
   int unsigned       m_cnt = 0;

   alu_writeback_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op), .in_tag(in_tag),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
      .occupancy(occupancy), .commit_cnt(commit_cnt),
      .fwd_tag(fwd_tag), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: a FIFO of {tag, y}; acceptance judged on pre-edge fullness.
   task automatic model_update();
      bit acc, com;
      if (!reset_n) begin
         q.delete();
         m_cnt = 0;
      end else begin
         acc = in_valid && (q.size() < DEPTH);
         com = (q.size() > 0) && wb_ready;
         if (com) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
         end
         if (acc && in_op != 5'b11111) q.push_back({in_tag, in_y});
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #2;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         bit          e_hit;
         logic [31:0] e_fd;
         chk("wb_valid", 32'(wb_valid), 32'(q.size() > 0));
         chk("occupancy", 32'(occupancy), 32'(q.size()));
         chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
         chk("commit_cnt", 32'(commit_cnt), m_cnt);
         if (q.size() > 0) begin
            chk("wb_data", wb_data, q[0][31:0]);
            chk("wb_tag", 32'(wb_tag), 32'(q[0][TAG_W+31:32]));
         end
         e_hit = 1'b0;
         e_fd  = '0;
`ifdef ALU_WB_FWD_EN
         foreach (q[i]) begin
            if (q[i][TAG_W+31:32] == fwd_tag) begin
               e_hit = 1'b1;
               e_fd  = q[i][31:0];
            end
         end
`endif
         chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
         chk("fwd_data", fwd_data, e_fd);
      end
   end

   initial begin
      logic [31:0] got[$];
      logic [31:0] exp_seq[5];
      reset_n = 1'b0; in_valid = 1'b0; in_y = '0; in_op = '0; in_tag = '0;
      wb_ready = 1'b0; fwd_tag = '0;
      cyc(); cyc();
      check_en = 1'b1;
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_wb_valid", 32'(wb_valid), 0);
      chk("rst_cnt", 32'(commit_cnt), 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_tag", 32'(wb_tag), 0);
      reset_n = 1'b1;
      cyc();
      chk("in_ready_after_rst", 32'(in_ready), 1);

      // Single result, one-cycle latency, then commit
      in_valid = 1'b1; in_y = 32'h5; in_tag = 5'd3; in_op = 5'd0; wb_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("lat_wb_valid", 32'(wb_valid), 1);
      chk("lat_wb_data", wb_data, 32'h5);
      chk("lat_wb_tag", 32'(wb_tag), 3);
      cyc();
      chk("one_commit_cnt", 32'(commit_cnt), 1);
      chk("one_commit_occ", 32'(occupancy), 0);

      // No-op is swallowed
      in_valid = 1'b1; in_y = 32'hDEAD_BEEF; in_op = 5'b11111;
      cyc();
      in_valid = 1'b0; in_op = 5'd0;
      chk("nop_wb_valid", 32'(wb_valid), 0);
      chk("nop_occ", 32'(occupancy), 0);

      // Fill under back-pressure, hold a fifth, then drain in order
      wb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_y = 32'hA + i; in_tag = 5'(i); in_op = 5'd1;
         cyc();
      end
      in_y = 32'hE; in_tag = 5'd9;
      chk("full_occ", 32'(occupancy), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      cyc(); cyc();
      chk("full_hold_occ", 32'(occupancy), 4);
      chk("full_hold_data", wb_data, 32'hA);
      wb_ready = 1'b1;
      for (int c = 0; c < 12 && got.size() < 5; c++) begin
         bit take;
         if (wb_valid) got.push_back(wb_data);
         take = in_valid && in_ready;
         cyc();
         if (take) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      exp_seq = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
      chk("drain_count", 32'(got.size()), 5);
      for (int i = 0; i < 5; i++) chk("drain_order", (i < got.size()) ? got[i] : 32'hX, exp_seq[i]);
      chk("drain_cnt", 32'(commit_cnt), 6);

      // Streaming accept+commit across pointer wraps
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_y = 32'h100 + i; in_tag = 5'(i); in_op = 5'd2;
         cyc();
         chk("stream_occ", 32'(occupancy), 1);
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_empty", 32'(occupancy), 0);
      chk("stream_cnt", 32'(commit_cnt), 16);

      // Forwarding: youngest of two same-tag entries
      wb_ready = 1'b0;
      in_valid = 1'b1; in_op = 5'd0; in_tag = 5'd7; in_y = 32'h11;
      cyc();
      in_y = 32'h22;
      cyc();
      in_valid = 1'b0;
      fwd_tag = 5'd7;
      #1;
`ifdef ALU_WB_FWD_EN
      chk("fwd7_hit", 32'(fwd_hit), 1);
      chk("fwd7_data", fwd_data, 32'h22);
`else
      chk("fwd7_hit_off", 32'(fwd_hit), 0);
      chk("fwd7_data_off", fwd_data, 0);
`endif
      fwd_tag = 5'd8;
      #1;
      chk("fwd8_hit", 32'(fwd_hit), 0);

      // Reset mid-operation with an accept attempt in the reset cycle
      in_valid = 1'b1; in_y = 32'h33; in_tag = 5'd1;
      cyc();
      chk("pre_rst_occ", 32'(occupancy), 3);
      reset_n = 1'b0; wb_ready = 1'b1;
      cyc();
      reset_n = 1'b1; in_valid = 1'b0;
      chk("mid_rst_valid", 32'(wb_valid), 0);
      chk("mid_rst_occ", 32'(occupancy), 0);
      chk("mid_rst_cnt", 32'(commit_cnt), 0);
      chk("mid_rst_ready", 32'(in_ready), 1);

      // Randomized traffic checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         reset_n  = ($urandom_range(0, 199) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_y     = $urandom;
         in_tag   = 5'($urandom_range(0, 7));
         in_op    = ($urandom_range(0, 7) == 0) ? 5'b11111 : 5'($urandom_range(0, 30));
         wb_ready = ($urandom_range(0, 2) != 0);
         fwd_tag  = 5'($urandom_range(0, 7));
         cyc();
      end
      reset_n = 1'b1; in_valid = 1'b0;
      cyc();
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_writeback_stage.md
ALU_WRITEBACK_STAGE -- requirements
Module: alu_writeback_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 SHALL have port in_valid  input  1  ALU result presented.
REQ-006 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-007 SHALL have port in_y  input  32  ALU result Y.
REQ-008 SHALL have port in_op  input  5  ALU_Op that produced in_y.
REQ-009 SHALL have port in_tag  input  TAG_W  destination register.
REQ-010 SHALL have port wb_valid  output  1  register-file write request.
REQ-011 SHALL have port wb_ready  input  1  register file accepts write.
REQ-012 SHALL have port wb_data  output  32  write data.
REQ-013 SHALL have port wb_tag  output  TAG_W  write address.
REQ-014 SHALL have port occupancy  output  log2(DEPTH)+1  entries held.
REQ-015 SHALL have port commit_cnt  output  16  completed writes, wraps 16'hFFFF->0.
REQ-016 SHALL have ports fwd_tag input TAG_W, fwd_hit output 1, fwd_data output 32 (present only per REQ-031).

Function
REQ-017 Accept = in_valid && in_ready; in_ready SHALL equal (occupancy < DEPTH), combinational from registered state only.
REQ-018 Accepted result with in_op == 5'b11111 (ALU no-op) SHALL be consumed and discarded: no entry, occupancy unchanged.
REQ-019 Any other accepted result SHALL be written to tail entry {in_y, in_tag}; tail pointer advances modulo DEPTH.
REQ-020 wb_valid SHALL be 1 whenever occupancy > 0; wb_data/wb_tag SHALL be the head entry, registered.
REQ-021 Latency: result accepted in cycle N into empty buffer SHALL appear on wb_valid in cycle N+1; no combinational in->wb path.
REQ-022 Commit = wb_valid && wb_ready; head pointer advances modulo DEPTH and commit_cnt increments by 1.
REQ-023 While wb_valid && !wb_ready, wb_data and wb_tag SHALL hold stable.
REQ-024 Simultaneous accept and commit SHALL leave occupancy unchanged; order strictly FIFO.
REQ-025 When full, in_ready = 0; a commit in that cycle SHALL NOT allow same-cycle accept (in_ready raised next cycle).
REQ-026 Empty: wb_valid = 0, wb_ready ignored, commit_cnt unchanged.
REQ-027 Pointer wrap at DEPTH-1 -> 0 SHALL preserve ordering and data.

Reset
REQ-028 reset_n = 0 at a clock edge SHALL clear pointers, occupancy, commit_cnt to 0, wb_data/wb_tag to 0, wb_valid to 0.
REQ-029 Reset mid-operation SHALL discard all buffered entries; accept/commit in that cycle SHALL be ignored.
REQ-030 in_ready SHALL be 1 in the first cycle after reset_n returns high.

Configuration
REQ-031 Macro ALU_WB_FWD_EN: defined -> fwd_hit = 1 when any valid entry tag equals fwd_tag, fwd_data = youngest matching entry (combinational); undefined -> fwd_tag unused, fwd_hit and fwd_data tied to 0, no compare logic.

Verification
REQ-032 Reset, then accept Y=32'h0000_0005 tag 3 op 00000 -> next cycle wb_valid=1, wb_data=5, wb_tag=3; wb_ready=1 -> commit_cnt=1, occupancy=0.
REQ-033 wb_ready=0, accept 4 results 32'hA..32'hD -> in_ready=0, occupancy=4; 5th held on input; release wb_ready -> writes A,B,C,D in order, then 5th.
REQ-034 Accept op 11111 with Y=32'hDEAD_BEEF -> no wb_valid, occupancy stays 0.
REQ-035 Continuous accept+commit for 10 results -> occupancy constant 1, pointers wrap, data order preserved, commit_cnt=10.
REQ-036 With ALU_WB_FWD_EN, buffer tag7=32'h11 then tag7=32'h22, fwd_tag=7 -> fwd_hit=1, fwd_data=32'h22; fwd_tag=8 -> fwd_hit=0.
REQ-037 Buffer 3 entries, assert reset_n=0 one cycle -> wb_valid=0, occupancy=0, commit_cnt=0, in_ready=1 next cycle.
